rgb_breath_pwm: RTL and testbench

- Parametrised successor to the switch-to-duty RGB decoder.
- Selects one of four per-channel colour presets from a 2-bit switch, scales the preset by a breathing envelope (triangle ramp), and drives N glitch-free PWM outputs directly.
- Sits between the board switches and the LED pins. Replaces the separate decoder plus the external duty wiring.

---
 rtl/rgb_breath_pwm.sv | 216 +++++++++++++++++++++
 tb/tb_rgb_breath_pwm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_breath_pwm.sv
// rtl/rgb_breath_pwm.sv - switch-selected RGB presets scaled by a triangle breathing envelope, driving glitch-free PWM
module rgb_breath_pwm #(
    parameter int                 CH       = 3,
    parameter int                 DW       = 8,
    parameter int                 STEP_DIV = 50000,
    parameter logic [CH*DW-1:0]   PRESET0  = 24'hFF1F7F,
    parameter logic [CH*DW-1:0]   PRESET1  = 24'hFFFF00,
    parameter logic [CH*DW-1:0]   PRESET2  = 24'h00FFFF,
    parameter logic [CH*DW-1:0]   PRESET3  = 24'hFF00FF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                breathe,
    input  logic [1:0]          sw,
    output logic [CH*DW-1:0]    duty_out,
    output logic [DW-1:0]       env_out,
    output logic [CH-1:0]       pwm_out,
    output logic                period_done
);

    localparam int             PW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]  P_LAST  = PW'(STEP_DIV - 1);
    localparam logic [DW-1:0]  ENV_TOP = {DW{1'b1}};
    localparam logic [DW-1:0]  ENV_PRE = {{(DW-1){1'b1}}, 1'b0};
    localparam logic [DW-1:0]  ENV_ONE = DW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        FALL,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DW-1:0]      env_nxt;
    logic               presc_clr;
    logic               done_nxt;

    logic [1:0]         sw_m;
    logic [1:0]         sw_s;
    logic [1:0]         sw_q;
    logic               sw_chg;

    logic [PW-1:0]      presc;
    logic               tick;

    logic [CH*DW-1:0]   target;
    logic [CH*DW-1:0]   scaled_nxt;
    logic [CH*DW-1:0]   scaled;
    logic [DW-1:0]      pwm_cnt;

    // Switches are asynchronous board inputs; sw_q lags sw_s by one cycle to flag a preset change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_m <= '0;
            sw_s <= '0;
            sw_q <= '0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
            sw_q <= sw_s;
        end
    end

    assign sw_chg = (sw_s != sw_q);
    assign tick   = en && (presc == P_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (!en || presc_clr || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            env_out     <= '0;
            period_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            env_out     <= env_nxt;
            period_done <= done_nxt;
        end
    end

    // Priority: en=0, then breathe=0, then preset change, then tick.
    always_comb begin
        state_nxt = state;
        env_nxt   = env_out;
        presc_clr = 1'b0;
        done_nxt  = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            env_nxt   = '0;
            presc_clr = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (breathe) begin
                        state_nxt = RISE;
                        env_nxt   = '0;
                    end else begin
                        state_nxt = HOLD;
                        env_nxt   = ENV_TOP;
                    end
                end
                RISE: begin
                    if (!breathe) begin
                        state_nxt = HOLD;
                        env_nxt   = ENV_TOP;
                    end else if (sw_chg) begin
                        env_nxt   = '0;
                        presc_clr = 1'b1;
                    end else if (tick) begin
                        if (env_out == ENV_PRE) begin
                            state_nxt = FALL;
                            env_nxt   = ENV_TOP;
                        end else begin
                            env_nxt   = env_out + ENV_ONE;
                        end
                    end
                end
                FALL: begin
                    if (!breathe) begin
                        state_nxt = HOLD;
                        env_nxt   = ENV_TOP;
                    end else if (sw_chg) begin
                        state_nxt = RISE;
                        env_nxt   = '0;
                        presc_clr = 1'b1;
                    end else if (tick) begin
                        if (env_out == ENV_ONE) begin
                            state_nxt = RISE;
                            env_nxt   = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            env_nxt   = env_out - ENV_ONE;
                        end
                    end
                end
                HOLD: begin
                    env_nxt = ENV_TOP;
                    if (breathe) begin
                        state_nxt = RISE;
                        env_nxt   = '0;
                        presc_clr = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    env_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        target = PRESET0;
        case (sw_s)
            2'b00:   target = PRESET0;
            2'b01:   target = PRESET1;
            2'b10:   target = PRESET2;
            default: target = PRESET3;
        endcase
    end

    // (env+1) scaling makes the full envelope reproduce the target exactly and env=0 give zero.
    for (genvar g = 0; g < CH; g++) begin : g_scale
        logic [2*DW:0]  prod;
        logic           unused_prod;

        always_comb begin
            prod = {{(DW+1){1'b0}}, target[g*DW +: DW]}
                 * {{DW{1'b0}}, ({1'b0, env_out} + (DW+1)'(1))};
        end

        assign scaled_nxt[g*DW +: DW] = prod[2*DW-1:DW];
        assign unused_prod            = ^{prod[2*DW], prod[DW-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scaled <= '0;
        end else begin
            scaled <= scaled_nxt;
        end
    end

    // Duty is only reloaded at the counter wrap so each PWM period sees one value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            duty_out <= '0;
            pwm_out  <= '0;
        end else if (!en) begin
            pwm_cnt  <= '0;
            duty_out <= '0;
            pwm_out  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + ENV_ONE;
            if (pwm_cnt == ENV_TOP) begin
                duty_out <= scaled;
            end
            for (int i = 0; i < CH; i++) begin
                pwm_out[i] <= (pwm_cnt < duty_out[i*DW +: DW]);
            end
        end
    end

endmodule

// File: tb/tb_rgb_breath_pwm.sv
// tb/tb_rgb_breath_pwm.sv - scoreboard bench for rgb_breath_pwm with directed vectors
module tb_rgb_breath_pwm;

    localparam int K_ENV    = 0;
    localparam int K_DUTY   = 1;
    localparam int K_PWM    = 2;
    localparam int K_PD     = 3;
    localparam int K_HIGH   = 4;
    localparam int K_CLR    = 5;
    localparam int K_PDLEFT = 6;

    typedef struct {
        int           kind;
        int           ch;
        logic [31:0]  exp;
        string        name;
    } item_t;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           breathe;
    logic [1:0]     sw;
    logic [23:0]    duty_out;
    logic [7:0]     env_out;
    logic [2:0]     pwm_out;
    logic           period_done;

    item_t          exp_q[$];
    int             pd_q[$];
    int             hi_cnt[3];
    int             cyc;
    int             n_checks;
    int             n_fail;
    int             c0;

    rgb_breath_pwm #(
        .CH       (3),
        .DW       (8),
        .STEP_DIV (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .breathe     (breathe),
        .sw          (sw),
        .duty_out    (duty_out),
        .env_out     (env_out),
        .pwm_out     (pwm_out),
        .period_done (period_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts PWM highs, checks period_done pulses, drains expected items.
    initial begin
        item_t it;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 3; i++) hi_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (pwm_out[i]) hi_cnt[i]++;
            end
            if (period_done === 1'b1) begin
                if (pd_q.size() == 0) chk("period_done_unexpected", 32'd1, 32'd0);
                else chk("period_done_cycle", cyc, pd_q.pop_front());
            end
            while (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                case (it.kind)
                    K_ENV:    chk(it.name, {24'd0, env_out}, it.exp);
                    K_DUTY:   chk(it.name, {8'd0, duty_out}, it.exp);
                    K_PWM:    chk(it.name, {29'd0, pwm_out}, it.exp);
                    K_PD:     chk(it.name, {31'd0, period_done}, it.exp);
                    K_HIGH:   chk(it.name, hi_cnt[it.ch], it.exp);
                    K_PDLEFT: chk(it.name, pd_q.size(), it.exp);
                    default:  for (int i = 0; i < 3; i++) hi_cnt[i] = 0;
                endcase
            end
        end
    end

    task automatic expect_item(input int kind, input int ch, input logic [31:0] e, input string name);
        item_t it;
        it.kind = kind;
        it.ch   = ch;
        it.exp  = e;
        it.name = name;
        exp_q.push_back(it);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_zero(input string tag);
        expect_item(K_ENV,  0, 32'h0, {tag, "_env"});
        expect_item(K_DUTY, 0, 32'h0, {tag, "_duty"});
        expect_item(K_PWM,  0, 32'h0, {tag, "_pwm"});
        expect_item(K_PD,   0, 32'h0, {tag, "_pd"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        breathe = 1'b0;
        sw      = 2'b00;
        tick(3);
        expect_zero("reset");
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Static full brightness on preset 0
        en = 1'b1;
        tick(600);
        expect_item(K_ENV,  0, 32'hFF,     "hold_env");
        expect_item(K_DUTY, 0, 32'hFF1F7F, "hold_duty");
        expect_item(K_CLR,  0, 32'h0,      "clr");
        tick(256);
        expect_item(K_HIGH, 0, 32'd127, "hold_high_r");
        expect_item(K_HIGH, 1, 32'd31,  "hold_high_g");
        expect_item(K_HIGH, 2, 32'd255, "hold_high_b");

        // Back to IDLE, select preset 1, start breathing
        en = 1'b0;
        sw = 2'b01;
        tick(4);
        expect_zero("en_off");
        c0 = cyc;
        pd_q.push_back(c0 + 1020);
        en      = 1'b1;
        breathe = 1'b1;
        tick(256);
        expect_item(K_ENV, 0, 32'h80, "rise_mid");
        tick(254);
        expect_item(K_ENV, 0, 32'hFF, "rise_top");
        tick(510);
        expect_item(K_ENV, 0, 32'h00, "fall_bottom");
        expect_item(K_PD,  0, 32'h1,  "period_done_level");
        tick(2);
        expect_item(K_ENV, 0, 32'h01, "rise_again");
        tick(126);
        expect_item(K_ENV,  0, 32'h40,     "pre_change_env");
        expect_item(K_DUTY, 0, 32'h010100, "pre_change_duty");

        // Preset change mid-rise: seen only after synchroniser + change detect
        sw = 2'b10;
        tick(2);
        expect_item(K_ENV, 0, 32'h41, "change_sync_delay");
        tick(1);
        expect_item(K_ENV, 0, 32'h00, "change_restart");
        tick(129);
        expect_item(K_ENV,  0, 32'h40,     "new_rise_env");
        expect_item(K_DUTY, 0, 32'h003F3F, "new_preset_duty");
        expect_item(K_CLR,  0, 32'h0,      "clr");

        // breathe drop mid-period: duty held until the next wrap
        tick(128);
        breathe = 1'b0;
        tick(1);
        expect_item(K_ENV, 0, 32'hFF, "breathe_off_env");
        tick(126);
        expect_item(K_DUTY, 0, 32'h003F3F, "duty_held_mid_period");
        tick(1);
        expect_item(K_DUTY, 0, 32'h00FFFF, "duty_after_wrap");
        expect_item(K_HIGH, 0, 32'd63, "period_high_r");
        expect_item(K_HIGH, 1, 32'd63, "period_high_g");
        expect_item(K_HIGH, 2, 32'd0,  "period_high_b");

        // en drop mid-fall, then restart
        breathe = 1'b1;
        tick(531);
        expect_item(K_ENV, 0, 32'hF5, "mid_fall_env");
        en = 1'b0;
        tick(1);
        expect_zero("en_drop");
        tick(3);
        en = 1'b1;
        tick(1);
        expect_item(K_ENV, 0, 32'h00, "restart_env0");
        tick(1);
        expect_item(K_ENV, 0, 32'h01, "restart_env1");

        // Asynchronous reset between clock edges
        breathe = 1'b0;
        tick(600);
        expect_item(K_ENV,  0, 32'hFF,     "pre_reset_env");
        expect_item(K_DUTY, 0, 32'h00FFFF, "pre_reset_duty");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        expect_zero("async_reset");
        tick(2);
        rst_n = 1'b1;
        en    = 1'b0;
        tick(2);

        expect_item(K_PDLEFT, 0, 32'd0, "period_done_missing");
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
